// File: rtl/hs_ram_arbiter_if.sv
// Bus bundle between the hiscore engine, the pause system, the game CPU and its work RAM.
// The slave modport is the arbiter's view; the master modport is everything around it.
interface hs_ram_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              cpu_ce;
    logic              pause_user;
    logic              hs_pause_req;
    logic              hs_access;
    logic              hs_we;
    logic [ADDR_W-1:0] hs_addr;
    logic [7:0]        hs_wdata;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_we;
    logic [7:0]        cpu_wdata;
    logic [7:0]        ram_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        cpu_rdata;
    logic [7:0]        hs_rdata;
    logic              cpu_pause;
    logic              hs_grant;
    logic              timeout_err;

    modport master (
        output cpu_ce, pause_user, hs_pause_req, hs_access, hs_we, hs_addr, hs_wdata,
               cpu_addr, cpu_we, cpu_wdata, ram_rdata,
        input  ram_addr, ram_we, ram_wdata, cpu_rdata, hs_rdata, cpu_pause, hs_grant,
               timeout_err
    );

    modport slave (
        input  cpu_ce, pause_user, hs_pause_req, hs_access, hs_we, hs_addr, hs_wdata,
               cpu_addr, cpu_we, cpu_wdata, ram_rdata,
        output ram_addr, ram_we, ram_wdata, cpu_rdata, hs_rdata, cpu_pause, hs_grant,
               timeout_err
    );
endinterface

// File: rtl/hs_ram_arbiter.sv
// Shares the CPU work-RAM port with the hiscore engine: pause the CPU at a bus-cycle
// boundary, let the bus quiesce, grant the port, then hold it briefly before handing it back.
module hs_ram_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int QUIESCE_CYC = 4,
    parameter int RELEASE_CYC = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input logic             clk_49m,
    input logic             reset,
    hs_ram_arbiter_if.slave bus
);
    localparam int CNT_W  = 4;
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0]  QUIESCE_LOAD = CNT_W'(QUIESCE_CYC - 1);
    localparam logic [CNT_W-1:0]  RELEASE_LOAD = CNT_W'(RELEASE_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST    = IDLE_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        QUIESCE,
        GRANT,
        RELEASE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              hs_grant_q;
    logic              timeout_err_q;
    logic [ADDR_W-1:0] last_addr;

    // NOTE: sequential state uses <= so every flop samples pre-edge values; blocking
    // assignments here would make the result depend on statement order.
    always_ff @(posedge clk_49m or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            idle_cnt      <= '0;
            hs_grant_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            last_addr     <= '0;
        end else begin
            last_addr <= bus.ram_addr;
            case (state)
                IDLE: begin
                    if (bus.hs_pause_req) state <= DRAIN;
                end
                DRAIN: begin
                    // A withdrawn request wins over a boundary in the same cycle.
                    if (!bus.hs_pause_req) begin
                        state <= IDLE;
                    end else if (bus.cpu_ce) begin
                        state <= QUIESCE;
                        cnt   <= QUIESCE_LOAD;
                    end
                end
                QUIESCE: begin
                    if (!bus.hs_pause_req) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state      <= GRANT;
                        hs_grant_q <= 1'b1;
                        idle_cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GRANT: begin
                    if (!bus.hs_pause_req && !bus.hs_access) begin
                        state      <= RELEASE;
                        cnt        <= RELEASE_LOAD;
                        hs_grant_q <= 1'b0;
                    end else if (bus.hs_access) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        // Engine holds the port without using it: take it back.
                        state         <= RELEASE;
                        cnt           <= RELEASE_LOAD;
                        hs_grant_q    <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_we    = bus.cpu_we;
        bus.ram_wdata = bus.cpu_wdata;
        case (state)
            QUIESCE: begin
                bus.ram_addr  = last_addr;
                bus.ram_we    = 1'b0;
                bus.ram_wdata = '0;
            end
            GRANT: begin
                bus.ram_addr  = bus.hs_addr;
                bus.ram_we    = bus.hs_we & bus.hs_access;
                bus.ram_wdata = bus.hs_wdata;
            end
            RELEASE: begin
                bus.ram_addr  = bus.hs_addr;
                bus.ram_we    = 1'b0;
                bus.ram_wdata = bus.hs_wdata;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; each consumer qualifies it by its own ownership.
    assign bus.cpu_rdata   = bus.ram_rdata;
    assign bus.hs_rdata    = bus.ram_rdata;
    assign bus.cpu_pause   = bus.pause_user | (state != IDLE);
    assign bus.hs_grant    = hs_grant_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Self-checking bench for hs_ram_arbiter: timing expectations are derived arithmetically
// from request/boundary cycles, and RAM contents are tracked in a sparse expected-memory map.
module tb_hs_ram_arbiter;
    localparam int ADDR_W      = 16;
    localparam int QUIESCE_CYC = 4;
    localparam int RELEASE_CYC = 4;
    localparam int TIMEOUT_CYC = 100;

    logic clk_49m = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    logic [7:0] exp_mem [int];
    logic [7:0] ram [0:(1<<ADDR_W)-1];

    hs_ram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    hs_ram_arbiter #(
        .ADDR_W(ADDR_W),
        .QUIESCE_CYC(QUIESCE_CYC),
        .RELEASE_CYC(RELEASE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_49m(clk_49m),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk_49m = ~clk_49m;

    // Work RAM with one-cycle synchronous read.
    always @(posedge clk_49m) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    task automatic tick();
        @(posedge clk_49m);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_49m);
    endtask

    task automatic drive_quiet();
        bus.cpu_ce       = 1'b0;
        bus.pause_user   = 1'b0;
        bus.hs_pause_req = 1'b0;
        bus.hs_access    = 1'b0;
        bus.hs_we        = 1'b0;
        bus.hs_addr      = '0;
        bus.hs_wdata     = '0;
        bus.cpu_addr     = '0;
        bus.cpu_we       = 1'b0;
        bus.cpu_wdata    = '0;
    endtask

    // Raise the request with boundaries every 4 clocks until the grant shows, bounded.
    task automatic acquire(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            tick();
            bus.hs_pause_req = 1'b1;
            bus.cpu_ce       = (t % 4 == 1);
            settle();
            if (bus.hs_grant === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        bus.cpu_ce = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL acquire: hs_grant got %b required 1 within 60 cycles", bus.hs_grant);
        end
    endtask

    task automatic release_port();
        bus.hs_pause_req = 1'b0;
        bus.hs_access    = 1'b0;
        bus.hs_we        = 1'b0;
        repeat (RELEASE_CYC + 3) tick();
    endtask

    task automatic test_reset();
        drive_quiet();
        reset          = 1'b1;
        bus.cpu_we     = 1'b1;
        bus.cpu_addr   = 16'h0BEE;
        bus.cpu_wdata  = 8'h3C;
        #3;
        vectors++;
        if (bus.hs_grant !== 1'b0 || bus.timeout_err !== 1'b0 || bus.cpu_pause !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: grant/err/pause got %b%b%b required 000",
                     bus.hs_grant, bus.timeout_err, bus.cpu_pause);
        end
        bus.pause_user = 1'b1;
        #1;
        vectors++;
        if (bus.cpu_pause !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pause_user: cpu_pause got %b required 1", bus.cpu_pause);
        end
        vectors++;
        if (bus.ram_addr !== 16'h0BEE || bus.ram_we !== 1'b1 || bus.ram_wdata !== 8'h3C) begin
            miscompares++;
            $display("FAIL reset_passthrough: addr/we/wdata got %h/%b/%h required 0bee/1/3c",
                     bus.ram_addr, bus.ram_we, bus.ram_wdata);
        end
        drive_quiet();
        repeat (2) @(negedge clk_49m);
        reset = 1'b0;
    endtask

    task automatic test_idle_passthrough();
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
        logic        p;
        for (int i = 0; i < 24; i++) begin
            tick();
            a = 16'($urandom_range(0, 16'h3FFF));
            d = 8'($urandom);
            w = 1'($urandom);
            p = 1'($urandom);
            bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_we = w; bus.pause_user = p;
            settle();
            vectors++;
            if (bus.ram_addr !== a || bus.ram_we !== w || bus.ram_wdata !== d ||
                bus.cpu_pause !== p || bus.hs_grant !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_random: addr/we/wdata/pause/grant got %h/%b/%h/%b/%b required %h/%b/%h/%b/0",
                         bus.ram_addr, bus.ram_we, bus.ram_wdata, bus.cpu_pause, bus.hs_grant, a, w, d, p);
            end
        end
        tick();
        bus.pause_user = 1'b0;
        bus.cpu_addr = 16'h1234; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'hA5;
        settle();
        vectors++;
        if (bus.ram_addr !== 16'h1234 || bus.ram_we !== 1'b1 || bus.ram_wdata !== 8'hA5 ||
            bus.cpu_pause !== 1'b0 || bus.hs_grant !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_fixed: addr/we/wdata/pause/grant got %h/%b/%h/%b/%b required 1234/1/a5/0/0",
                     bus.ram_addr, bus.ram_we, bus.ram_wdata, bus.cpu_pause, bus.hs_grant);
        end
        tick();
        bus.cpu_we = 1'b0;
        tick();
        settle();
        vectors++;
        if (bus.cpu_rdata !== 8'hA5) begin
            miscompares++;
            $display("FAIL idle_cpu_read: cpu_rdata got %h required a5", bus.cpu_rdata);
        end
    endtask

    task automatic test_grant_latency();
        for (int trial = 0; trial < 4; trial++) begin
            int phase;
            int first_ce;
            int gcycle;
            phase    = (trial == 0) ? 3 : int'($urandom_range(0, 3));
            first_ce = 1;
            while ((first_ce + phase) % 4 != 0) first_ce++;
            // DRAIN ends on the first boundary, then QUIESCE_CYC quiet cycles precede the grant.
            gcycle = first_ce + QUIESCE_CYC + 1;
            for (int t = 0; t <= gcycle + 2; t++) begin
                tick();
                bus.hs_pause_req = 1'b1;
                bus.cpu_ce       = ((t + phase) % 4 == 0);
                bus.cpu_we       = 1'b1;
                bus.cpu_addr     = 16'($urandom);
                bus.cpu_wdata    = 8'($urandom);
                settle();
                vectors++;
                if (bus.cpu_pause !== (t >= 1) || bus.hs_grant !== (t >= gcycle) ||
                    bus.ram_we !== (t <= first_ce)) begin
                    miscompares++;
                    $display("FAIL grant_latency t=%0d phase=%0d: pause/grant/ram_we got %b%b%b required %b%b%b",
                             t, phase, bus.cpu_pause, bus.hs_grant, bus.ram_we,
                             t >= 1, t >= gcycle, t <= first_ce);
                end
            end
            bus.cpu_ce = 1'b0;
            bus.cpu_we = 1'b0;
            release_port();
        end
    endtask

    task automatic test_restore_burst();
        bit          ok;
        int          pulses;
        int          rd_addr [8];
        logic [15:0] a;
        logic [7:0]  d;
        logic        acc;
        acquire(ok);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            bus.hs_access = 1'b1; bus.hs_we = 1'b1;
            bus.hs_addr = 16'h4000 + 16'(i); bus.hs_wdata = 8'(i);
            bus.cpu_we = 1'b1; bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 8'($urandom);
            exp_mem[16'h4000 + i] = 8'(i);
            settle();
            if (bus.ram_we === 1'b1) pulses++;
            vectors++;
            if (bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h4000 + 16'(i) || bus.ram_wdata !== 8'(i)) begin
                miscompares++;
                $display("FAIL burst_write %0d: we/addr/wdata got %b/%h/%h required 1/%h/%h",
                         i, bus.ram_we, bus.ram_addr, bus.ram_wdata, 16'h4000 + 16'(i), 8'(i));
            end
        end
        vectors++;
        if (pulses != 16) begin
            miscompares++;
            $display("FAIL burst_pulses: ram_we pulses got %0d required 16", pulses);
        end
        // Random writes with random access gaps; gaps must never reach the RAM.
        for (int i = 0; i < 16; i++) begin
            tick();
            a = 16'h4000 + 16'($urandom_range(0, 31));
            d = 8'($urandom);
            acc = 1'($urandom);
            bus.hs_access = acc; bus.hs_we = 1'b1; bus.hs_addr = a; bus.hs_wdata = d;
            if (acc) exp_mem[int'(a)] = d;
            settle();
            vectors++;
            if (bus.ram_we !== acc || bus.hs_grant !== 1'b1) begin
                miscompares++;
                $display("FAIL random_write %0d: ram_we/grant got %b/%b required %b/1",
                         i, bus.ram_we, bus.hs_grant, acc);
            end
        end
        for (int i = 0; i < 8; i++) rd_addr[i] = 16'h4000 + int'($urandom_range(0, 31));
        for (int i = 0; i <= 8; i++) begin
            tick();
            bus.hs_we = 1'b0;
            bus.cpu_we = 1'b0;
            bus.hs_access = (i < 8);
            if (i < 8) bus.hs_addr = 16'(rd_addr[i]);
            settle();
            if (i > 0) begin
                vectors++;
                if (bus.hs_rdata !== exp_mem[rd_addr[i-1]]) begin
                    miscompares++;
                    $display("FAIL hs_read %h: hs_rdata got %h required %h",
                             rd_addr[i-1], bus.hs_rdata, exp_mem[rd_addr[i-1]]);
                end
            end
        end
        tick();
        bus.hs_pause_req = 1'b0;
        bus.hs_access    = 1'b0;
        bus.cpu_we       = 1'b1;
        settle();
        for (int j = 1; j <= RELEASE_CYC + 1; j++) begin
            tick();
            settle();
            vectors++;
            if (bus.hs_grant !== 1'b0 || bus.cpu_pause !== (j <= RELEASE_CYC) ||
                bus.ram_we !== (j > RELEASE_CYC)) begin
                miscompares++;
                $display("FAIL release j=%0d: grant/pause/ram_we got %b%b%b required 0%b%b",
                         j, bus.hs_grant, bus.cpu_pause, bus.ram_we, j <= RELEASE_CYC, j > RELEASE_CYC);
            end
        end
        bus.cpu_we = 1'b0;
    endtask

    task automatic test_abort();
        for (int t = 0; t < 7; t++) begin
            tick();
            bus.cpu_ce       = 1'b0;
            bus.hs_pause_req = (t < 2);
            settle();
            vectors++;
            if (bus.cpu_pause !== (t == 1 || t == 2) || bus.hs_grant !== 1'b0) begin
                miscompares++;
                $display("FAIL abort t=%0d: pause/grant got %b%b required %b0",
                         t, bus.cpu_pause, bus.hs_grant, t == 1 || t == 2);
            end
        end
    endtask

    task automatic test_pause_overlap();
        bit ok;
        bus.pause_user = 1'b1;
        acquire(ok);
        release_port();
        bus.cpu_we = 1'b1;
        settle();
        vectors++;
        if (bus.cpu_pause !== 1'b1 || bus.hs_grant !== 1'b0 || bus.ram_we !== 1'b1) begin
            miscompares++;
            $display("FAIL overlap_after_release: pause/grant/ram_we got %b%b%b required 101",
                     bus.cpu_pause, bus.hs_grant, bus.ram_we);
        end
        tick();
        bus.pause_user = 1'b0;
        bus.cpu_we     = 1'b0;
        settle();
        vectors++;
        if (bus.cpu_pause !== 1'b0) begin
            miscompares++;
            $display("FAIL overlap_unpause: cpu_pause got %b required 0", bus.cpu_pause);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int held;
        acquire(ok);
        vectors++;
        if (bus.timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_pre: timeout_err got %b required 0", bus.timeout_err);
        end
        held = 1;
        for (int t = 0; t < 300; t++) begin
            tick();
            settle();
            if (bus.hs_grant === 1'b1) held++;
            else break;
        end
        vectors++;
        if (held != TIMEOUT_CYC) begin
            miscompares++;
            $display("FAIL timeout_grant_cycles: got %0d required %0d", held, TIMEOUT_CYC);
        end
        vectors++;
        if (bus.timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_set: timeout_err got %b required 1", bus.timeout_err);
        end
        release_port();
        repeat (20) tick();
        settle();
        vectors++;
        if (bus.timeout_err !== 1'b1 || bus.hs_grant !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_sticky: err/grant got %b%b required 10", bus.timeout_err, bus.hs_grant);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        acquire(ok);
        tick();
        bus.hs_access = 1'b1; bus.hs_we = 1'b1;
        bus.hs_addr = 16'h4321; bus.hs_wdata = 8'h5A;
        bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0777; bus.cpu_wdata = 8'h11;
        settle();
        vectors++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h4321) begin
            miscompares++;
            $display("FAIL async_pre_write: we/addr got %b/%h required 1/4321", bus.ram_we, bus.ram_addr);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.hs_grant !== 1'b0 || bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h0777 ||
            bus.timeout_err !== 1'b0 || bus.cpu_pause !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: grant/we/addr/err/pause got %b/%b/%h/%b/%b required 0/1/0777/0/0",
                     bus.hs_grant, bus.ram_we, bus.ram_addr, bus.timeout_err, bus.cpu_pause);
        end
        drive_quiet();
        repeat (2) @(negedge clk_49m);
        reset = 1'b0;
        tick();
        settle();
        vectors++;
        if (bus.cpu_pause !== 1'b0 || bus.hs_grant !== 1'b0) begin
            miscompares++;
            $display("FAIL async_post: pause/grant got %b%b required 00", bus.cpu_pause, bus.hs_grant);
        end
    endtask

    initial begin
        test_reset();
        test_idle_passthrough();
        test_grant_latency();
        test_restore_burst();
        test_abort();
        test_pause_overlap();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
